// File: rtl/iq_src_arbiter.sv
// Frame-granular round-robin arbiter sharing one FIFO-style IQ read port between sources A and B.
// Define IQ_ARB_TIMEOUT_EN to abort a grant after TIMEOUT consecutive starved cycles.
module iq_src_arbiter #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        a_empty,
  output logic        a_rd_en,
  input  logic [31:0] a_dout,
  input  logic        b_empty,
  output logic        b_rd_en,
  input  logic [31:0] b_dout,
  output logic        iq_empty,
  input  logic        iq_rd_en,
  output logic [31:0] iq_dout,
  output logic        src_sel,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] frames_a,
  output logic [15:0] frames_b
);

  if (FRAME_LEN < 1 || FRAME_LEN > 65535 || TIMEOUT < 1) begin : g_param_check
    $error("iq_src_arbiter: FRAME_LEN or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  state_t      state_reg;
  logic [15:0] word_cnt_reg;
  logic        last_reg;          // 0 = A served last, 1 = B served last
  logic        src_sel_reg;
  logic        frame_start_reg;
  logic        frame_done_reg;
  logic [15:0] frames_a_reg;
  logic [15:0] frames_b_reg;

  logic gnt_empty;
  logic accept;
  logic starve_hit;

  // Passthrough is purely combinational from the grant state, so an async reset drops it at once.
  assign gnt_empty = (state_reg == GNT_B) ? b_empty : a_empty;
  assign iq_empty  = (state_reg == IDLE) || gnt_empty;
  assign a_rd_en   = (state_reg == GNT_A) && iq_rd_en && !a_empty;
  assign b_rd_en   = (state_reg == GNT_B) && iq_rd_en && !b_empty;
  assign accept    = iq_rd_en && !iq_empty;

  always_comb begin
    iq_dout = '0;
    if (state_reg == GNT_A)      iq_dout = a_dout;
    else if (state_reg == GNT_B) iq_dout = b_dout;
  end

`ifdef IQ_ARB_TIMEOUT_EN
  localparam int unsigned STARVE_W = $clog2(TIMEOUT + 1);

  logic [STARVE_W-1:0] starve_cnt_reg;
  logic                frame_abort_reg;

  assign starve_hit = (state_reg != IDLE) && gnt_empty &&
                      (starve_cnt_reg == STARVE_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_reg  <= '0;
      frame_abort_reg <= 1'b0;
    end else begin
      frame_abort_reg <= starve_hit;
      if (state_reg == IDLE || !gnt_empty || starve_hit)
        starve_cnt_reg <= '0;
      else
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  assign frame_abort = frame_abort_reg;
`else
  assign starve_hit  = 1'b0;
  assign frame_abort = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      word_cnt_reg    <= '0;
      last_reg        <= 1'b1;
      src_sel_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      frames_a_reg    <= '0;
      frames_b_reg    <= '0;
    end else begin
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable && (!a_empty || !b_empty)) begin
            // A wins when it is the only candidate or when B was served last.
            if (!a_empty && (b_empty || last_reg)) begin
              state_reg   <= GNT_A;
              last_reg    <= 1'b0;
              src_sel_reg <= 1'b0;
            end else begin
              state_reg   <= GNT_B;
              last_reg    <= 1'b1;
              src_sel_reg <= 1'b1;
            end
            word_cnt_reg    <= '0;
            frame_start_reg <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            word_cnt_reg <= word_cnt_reg + 16'd1;
            if (word_cnt_reg == LAST_IDX) begin
              state_reg      <= IDLE;
              frame_done_reg <= 1'b1;
              if (state_reg == GNT_B) frames_b_reg <= frames_b_reg + 16'd1;
              else                    frames_a_reg <= frames_a_reg + 16'd1;
            end
          end else if (starve_hit) begin
            state_reg    <= IDLE;
            word_cnt_reg <= '0;
            last_reg     <= (state_reg == GNT_B);
          end
        end
      endcase
    end
  end

  assign src_sel     = src_sel_reg;
  assign frame_start = frame_start_reg;
  assign frame_done  = frame_done_reg;
  assign frames_a    = frames_a_reg;
  assign frames_b    = frames_b_reg;

endmodule
